// File: rtl/load_use_hazard_ctrl_if.sv
// Signal bundle between the decode-stage pipeline registers and the load-use hazard detector.
// The pipeline side drives the operand and load fields; the detector returns stall controls.
interface load_use_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 6,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] rs1_IF_ID;
  logic [REG_ADDR_W-1:0] rs2_IF_ID;
  logic                  rs1_used_IF_ID;
  logic                  rs2_used_IF_ID;
  logic                  valid_IF_ID;
  logic                  flush;
  logic [REG_ADDR_W-1:0] rd_ID_EX;
  logic                  mem_read_ID_EX;
  logic                  stall;
  logic                  bubble;
  logic [LOAD_LAT-1:0]   hazard_stage;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output rs1_IF_ID, rs2_IF_ID, rs1_used_IF_ID, rs2_used_IF_ID, valid_IF_ID, flush,
           rd_ID_EX, mem_read_ID_EX,
    input  stall, bubble, hazard_stage, stall_cycles
  );

  modport slave (
    input  rs1_IF_ID, rs2_IF_ID, rs1_used_IF_ID, rs2_used_IF_ID, valid_IF_ID, flush,
           rd_ID_EX, mem_read_ID_EX,
    output stall, bubble, hazard_stage, stall_cycles
  );
endinterface

// File: rtl/load_use_hazard_ctrl.sv
// Load-use hazard detector for loads whose data is forwardable LOAD_LAT cycles after EX entry.
// Tracks in-flight loads in a free-running shift pipeline and counts stall cycles (saturating).
module load_use_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W      = 6,
  parameter int unsigned LOAD_LAT        = 1,
  parameter bit          ZERO_REG_EXEMPT = 1'b1,
  parameter int unsigned CNT_W           = 32
) (
  input logic                   clk,
  input logic                   rst,
  load_use_hazard_ctrl_if.slave bus
);

  logic [LOAD_LAT-1:0]                  stage_valid;
  logic [LOAD_LAT-1:0][REG_ADDR_W-1:0] stage_rd;
  logic [LOAD_LAT-1:0]                  hazard_stage;
  logic                                 stall;
  logic [CNT_W-1:0]                     stall_cycles_q, stall_cycles_d;

  // Stage 0 is the load currently sitting in ID/EX.
  assign stage_valid[0] = bus.mem_read_ID_EX;
  assign stage_rd[0]    = bus.rd_ID_EX;

  // Stages past EX never stall, so the shift is unconditional.
  if (LOAD_LAT > 1) begin : g_lp
    logic [LOAD_LAT-1:1]                  lp_valid_q;
    logic [LOAD_LAT-1:1][REG_ADDR_W-1:0] lp_rd_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lp_valid_q <= '0;
        lp_rd_q    <= '0;
      end else begin
        lp_valid_q <= stage_valid[LOAD_LAT-2:0];
        lp_rd_q    <= stage_rd[LOAD_LAT-2:0];
      end
    end

    assign stage_valid[LOAD_LAT-1:1] = lp_valid_q;
    assign stage_rd[LOAD_LAT-1:1]    = lp_rd_q;
  end

  for (genvar k = 0; k < LOAD_LAT; k++) begin : g_match
    logic rs1_hit, rs2_hit, zero_skip;
    assign rs1_hit   = bus.rs1_used_IF_ID && (stage_rd[k] == bus.rs1_IF_ID);
    assign rs2_hit   = bus.rs2_used_IF_ID && (stage_rd[k] == bus.rs2_IF_ID);
    assign zero_skip = ZERO_REG_EXEMPT && (stage_rd[k] == '0);
    assign hazard_stage[k] = !rst && stage_valid[k] && (rs1_hit || rs2_hit) && !zero_skip;
  end

  // Flush and empty slots only suppress the request; tracked loads keep shifting.
  assign stall = bus.valid_IF_ID && !bus.flush && !rst && (|hazard_stage);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign bus.stall        = stall;
  assign bus.bubble       = stall;
  assign bus.hazard_stage = hazard_stage;
  assign bus.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_load_use_hazard_ctrl.sv
// Directed bench for load_use_hazard_ctrl: a LOAD_LAT=1/CNT_W=4 instance and a LOAD_LAT=3 one,
// with expected outputs queued as each step is driven and popped when the outputs are sampled.
module tb_load_use_hazard_ctrl;

  typedef struct packed {
    logic        stall;
    logic [2:0]  hs;
    logic [31:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  exp_t  qa[$];
  exp_t  qb[$];
  string tag_a[$];
  string tag_b[$];

  load_use_hazard_ctrl_if #(.REG_ADDR_W(6), .LOAD_LAT(1), .CNT_W(4))  ba ();
  load_use_hazard_ctrl_if #(.REG_ADDR_W(6), .LOAD_LAT(3), .CNT_W(32)) bb ();

  load_use_hazard_ctrl #(
    .REG_ADDR_W(6), .LOAD_LAT(1), .ZERO_REG_EXEMPT(1'b1), .CNT_W(4)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ba.slave)
  );

  load_use_hazard_ctrl #(
    .REG_ADDR_W(6), .LOAD_LAT(3), .ZERO_REG_EXEMPT(1'b1), .CNT_W(32)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_a(input logic [5:0] rs1, input logic [5:0] rs2, input logic u1,
                         input logic u2, input logic v, input logic fl, input logic [5:0] rd,
                         input logic mr);
    ba.rs1_IF_ID = rs1; ba.rs2_IF_ID = rs2; ba.rs1_used_IF_ID = u1; ba.rs2_used_IF_ID = u2;
    ba.valid_IF_ID = v; ba.flush = fl; ba.rd_ID_EX = rd; ba.mem_read_ID_EX = mr;
  endtask

  task automatic drive_b(input logic [5:0] rs1, input logic [5:0] rs2, input logic u1,
                         input logic u2, input logic v, input logic fl, input logic [5:0] rd,
                         input logic mr);
    bb.rs1_IF_ID = rs1; bb.rs2_IF_ID = rs2; bb.rs1_used_IF_ID = u1; bb.rs2_used_IF_ID = u2;
    bb.valid_IF_ID = v; bb.flush = fl; bb.rd_ID_EX = rd; bb.mem_read_ID_EX = mr;
  endtask

  task automatic cmp(input string t, input string f, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s.%s got %0h want %0h", t, f, obs, exp);
    end
  endtask

  task automatic push(input string t, input logic sa, input logic [2:0] ha,
                      input logic [31:0] ca, input logic sb, input logic [2:0] hb,
                      input logic [31:0] cb);
    exp_t e;
    e.stall = sa; e.hs = ha; e.cnt = ca;
    qa.push_back(e); tag_a.push_back({t, "_a"});
    e.stall = sb; e.hs = hb; e.cnt = cb;
    qb.push_back(e); tag_b.push_back({t, "_b"});
  endtask

  task automatic check_now();
    exp_t  e;
    string t;
    if (qa.size() == 0 || qb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL scoreboard empty got %0d/%0d want >0", qa.size(), qb.size());
    end else begin
      e = qa.pop_front(); t = tag_a.pop_front();
      cmp(t, "stall",  32'(ba.stall),        32'(e.stall));
      cmp(t, "bubble", 32'(ba.bubble),       32'(e.stall));
      cmp(t, "hs",     32'(ba.hazard_stage), 32'(e.hs[0]));
      cmp(t, "cnt",    32'(ba.stall_cycles), e.cnt);
      e = qb.pop_front(); t = tag_b.pop_front();
      cmp(t, "stall",  32'(bb.stall),        32'(e.stall));
      cmp(t, "bubble", 32'(bb.bubble),       32'(e.stall));
      cmp(t, "hs",     32'(bb.hazard_stage), 32'(e.hs));
      cmp(t, "cnt",    bb.stall_cycles,      e.cnt);
    end
  endtask

  // Queue expectations, sample on the falling edge, then advance past the rising edge.
  task automatic sc(input string t, input logic sa, input logic [2:0] ha, input logic [31:0] ca,
                    input logic sb, input logic [2:0] hb, input logic [31:0] cb);
    push(t, sa, ha, ca, sb, hb, cb);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 7, 0, 1, 1, 0, 7, 1);
    sc("reset", 0, 3'b000, 0, 0, 3'b000, 0);
    rst = 1'b0;
    drive_b(0, 0, 0, 0, 0, 0, 0, 0);

    // LOAD_LAT=1 instance
    drive_a(5, 0, 1, 0, 1, 0, 5, 1);   sc("a_lat1",    1, 3'b001, 0, 0, 3'b000, 0);
    drive_a(5, 0, 1, 0, 1, 0, 0, 0);   sc("a_bubble",  0, 3'b000, 1, 0, 3'b000, 0);
    drive_a(0, 0, 1, 0, 1, 0, 0, 1);   sc("a_x0",      0, 3'b000, 1, 0, 3'b000, 0);
    drive_a(9, 3, 0, 1, 1, 0, 9, 1);   sc("a_unused",  0, 3'b000, 1, 0, 3'b000, 0);
    drive_a(5, 0, 1, 0, 1, 1, 5, 1);   sc("a_flush",   0, 3'b001, 1, 0, 3'b000, 0);
    drive_a(5, 0, 1, 0, 0, 0, 5, 1);   sc("a_novalid", 0, 3'b001, 1, 0, 3'b000, 0);
    drive_a(0, 12, 0, 1, 1, 0, 12, 1); sc("a_rs2",     1, 3'b001, 1, 0, 3'b000, 0);
    for (int i = 0; i < 20; i++) begin
      sc("a_sat", 1, 3'b001, (2 + i > 15) ? 32'd15 : 32'(2 + i), 0, 3'b000, 0);
    end
    drive_a(0, 0, 0, 0, 0, 0, 0, 0);   sc("a_hold",    0, 3'b000, 15, 0, 3'b000, 0);

    // LOAD_LAT=3: immediate consumer stalls three cycles
    drive_b(0, 7, 0, 1, 1, 0, 7, 1);   sc("b_l3_0", 0, 3'b000, 15, 1, 3'b001, 0);
    drive_b(0, 7, 0, 1, 1, 0, 0, 0);   sc("b_l3_1", 0, 3'b000, 15, 1, 3'b010, 1);
    sc("b_l3_2", 0, 3'b000, 15, 1, 3'b100, 2);
    sc("b_l3_3", 0, 3'b000, 15, 0, 3'b000, 3);

    // Consumer two instructions behind the load stalls two cycles
    drive_b(1, 2, 1, 1, 1, 0, 7, 1);   sc("b_indep", 0, 3'b000, 15, 0, 3'b000, 3);
    drive_b(7, 0, 1, 0, 1, 0, 0, 0);   sc("b_rd_1",  0, 3'b000, 15, 1, 3'b010, 3);
    sc("b_rd_2", 0, 3'b000, 15, 1, 3'b100, 4);
    sc("b_rd_3", 0, 3'b000, 15, 0, 3'b000, 5);

    // Flush / empty slot suppress only the request
    drive_b(7, 0, 1, 0, 1, 1, 7, 1);   sc("b_flush",   0, 3'b000, 15, 0, 3'b001, 5);
    drive_b(7, 0, 1, 0, 1, 0, 0, 0);   sc("b_aflush",  0, 3'b000, 15, 1, 3'b010, 5);
    drive_b(7, 0, 1, 0, 0, 0, 0, 0);   sc("b_novalid", 0, 3'b000, 15, 0, 3'b100, 6);
    drive_b(7, 0, 1, 0, 1, 0, 0, 0);   sc("b_clear",   0, 3'b000, 15, 0, 3'b000, 6);

    // Asynchronous reset in the second stall cycle
    drive_b(0, 7, 0, 1, 1, 0, 7, 1);   sc("b_rs_0", 0, 3'b000, 15, 1, 3'b001, 6);
    drive_b(0, 7, 0, 1, 1, 0, 0, 0);
    push("b_rs_1", 0, 3'b000, 15, 1, 3'b010, 7);
    @(negedge clk);
    check_now();
    #1;
    rst = 1'b1;
    push("b_rs_async", 0, 3'b000, 0, 0, 3'b000, 0);
    #1;
    check_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sc("b_post_rst",  0, 3'b000, 0, 0, 3'b000, 0);
    sc("b_post_rst2", 0, 3'b000, 0, 0, 3'b000, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
